// File: rtl/prog_uart_loader.sv
// ---------------------------------------------------------------------------
// prog_uart_loader
// UART program loader sitting upstream of main memory. Hunts for a 4-byte
// magic sequence on the programming RX line, reads a 32-bit little-endian
// word count, then streams that many little-endian words into the RAM write
// port. The core is held in reset and the program-mode LED is lit while a
// load is in progress. A framing error or an inter-byte timeout aborts the
// load with a single-cycle error pulse.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous reset, active low
//   prog_rx_i        UART RX line, idle high, 8N1, asynchronous to clk_i
//   wr_en_o          one-cycle RAM write strobe
//   wr_addr_o        RAM word address
//   wr_data_o        RAM write data
//   wr_strb_o        byte enables, 4'hF with wr_en_o, else 4'h0
//   system_reset_o   active-low core reset, low while loading
//   prog_mode_led_o  high while receiving the length or the image
//   prog_err_o       one-cycle pulse when a load is aborted
// ---------------------------------------------------------------------------
module prog_uart_loader #(
   parameter int unsigned CLK_FREQ    = 100_000_000,
   parameter int unsigned BAUD        = 115200,
   parameter int unsigned RAM_DEPTH   = 32'h40000,
   parameter int unsigned ADDR_W      = $clog2(RAM_DEPTH * 4) - 2,
   parameter logic [31:0] MAGIC       = 32'h4B47_4F54,
   parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              prog_rx_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic [3:0]        wr_strb_o,
   output logic              system_reset_o,
   output logic              prog_mode_led_o,
   output logic              prog_err_o
);

   localparam int unsigned CPB  = CLK_FREQ / BAUD;
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned BW   = $clog2(CPB);
   localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_LEN,
      ST_LOAD,
      ST_DONE
   } state_e;

   // ---------------- RX front end state ----------------
   logic              rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e         rx_state_q, rx_state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        rx_byte_q, rx_byte_d;
   logic              byte_valid_q, byte_valid_d;
   logic              frame_err_q, frame_err_d;

   // ---------------- loader FSM state ----------------
   state_e            state_q, state_d;
   logic [1:0]        m_q, m_d;
   logic [31:0]       n_q, n_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [3:0]        wr_strb_q, wr_strb_d;
   logic              sys_rst_q, sys_rst_d;
   logic              led_q, led_d;
   logic              err_q, err_d;

   logic [7:0]        magic_byte;
   logic [31:0]       word_next;
   logic [31:0]       n_next;

   // RX framing: start detect, mid-start glitch filter, data and stop sampling
   always_comb begin
      rx_state_d   = rx_state_q;
      baud_d       = baud_q + BW'(1);
      bit_d        = bit_q;
      shift_d      = shift_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            baud_d = '0;
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (baud_q == BW'(HALF - 1)) begin
               baud_d     = '0;
               bit_d      = '0;
               // line back high at mid-start means the edge was a glitch
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_q == BW'(CPB - 1)) begin
               baud_d  = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (baud_q == BW'(CPB - 1)) begin
               baud_d     = '0;
               // leave at the stop sample so a back-to-back start edge is seen
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
                  rx_byte_d    = shift_q;
               end else begin
                  frame_err_d  = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Loader: magic hunt, length capture, word assembly and RAM writes
   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      timer_d    = timer_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_d      = 1'b0;
      magic_byte = 8'(MAGIC >> {m_q, 3'b000});
      word_next  = {rx_byte_q, word_q[31:8]};
      n_next     = {rx_byte_q, n_q[31:8]};

      case (state_q)
         ST_HUNT: begin
            timer_d = '0;
            if (byte_valid_q) begin
               if (rx_byte_q == magic_byte) begin
                  m_d = m_q + 2'd1;
                  if (m_q == 2'd3) begin
                     state_d = ST_LEN;
                     n_d     = '0;
                  end
               end else begin
                  // a miss may itself be the first magic byte
                  m_d = (rx_byte_q == MAGIC[7:0]) ? 2'd1 : 2'd0;
               end
            end
         end
         ST_LEN, ST_LOAD: begin
            timer_d = timer_q + TW'(1);
            if (frame_err_q || (timer_q == TW'(TIMEOUT_CYC - 1))) begin
               err_d   = 1'b1;
               state_d = ST_HUNT;
               m_d     = '0;
               timer_d = '0;
            end else if (byte_valid_q) begin
               // count from 1 so the abort lands TIMEOUT_CYC after byte_valid
               timer_d = TW'(1);
               m_d     = m_q + 2'd1;
               if (state_q == ST_LEN) begin
                  n_d = n_next;
                  if (m_q == 2'd3) begin
                     state_d = (n_next == '0) ? ST_DONE : ST_LOAD;
                     cnt_d   = '0;
                  end
               end else begin
                  word_d = word_next;
                  if (m_q == 2'd3) begin
                     // words beyond the RAM are consumed but never written
                     if (cnt_q < RAM_DEPTH) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(cnt_q);
                        wr_data_d = word_next;
                     end
                     cnt_d = cnt_q + 32'd1;
                     if ((cnt_q + 32'd1) == n_q) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_HUNT;
            m_d     = '0;
            timer_d = '0;
         end
         default: state_d = ST_HUNT;
      endcase

      wr_strb_d = wr_en_d ? 4'hF : 4'h0;
      sys_rst_d = (state_d == ST_HUNT);
      led_d     = (state_d == ST_LEN) || (state_d == ST_LOAD);
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         state_q      <= ST_HUNT;
         m_q          <= '0;
         n_q          <= '0;
         cnt_q        <= '0;
         word_q       <= '0;
         timer_q      <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_strb_q    <= '0;
         sys_rst_q    <= 1'b1;
         led_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rx_meta_q    <= prog_rx_i;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_state_q   <= rx_state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         state_q      <= state_d;
         m_q          <= m_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         timer_q      <= timer_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_strb_q    <= wr_strb_d;
         sys_rst_q    <= sys_rst_d;
         led_q        <= led_d;
         err_q        <= err_d;
      end
   end

   assign wr_en_o         = wr_en_q;
   assign wr_addr_o       = wr_addr_q;
   assign wr_data_o       = wr_data_q;
   assign wr_strb_o       = wr_strb_q;
   assign system_reset_o  = sys_rst_q;
   assign prog_mode_led_o = led_q;
   assign prog_err_o      = err_q;

endmodule

// File: tb/tb_prog_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_uart_loader
// Self-checking bench for prog_uart_loader at CPB=10, TIMEOUT_CYC=500,
// RAM_DEPTH=16. Expected RAM writes are queued as frames are sent and are
// popped and compared whenever the DUT strobes wr_en_o.
// ---------------------------------------------------------------------------
module tb_prog_uart_loader;

   localparam int unsigned CLK_FREQ = 1_000_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int unsigned CPB      = 10;
   localparam int unsigned TIMEOUT  = 500;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned AW       = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx    = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_strb;
   logic          sys_rst;
   logic          led;
   logic          perr;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int n_writes  = 0;
   int n_err     = 0;
   int n_lo      = 0;
   int n_led     = 0;
   int err_cyc   = 0;
   int last_fall = 0;
   wr_t exp_q[$];

   prog_uart_loader #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .RAM_DEPTH  (DEPTH),
      .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .prog_rx_i      (rx),
      .wr_en_o        (wr_en),
      .wr_addr_o      (wr_addr),
      .wr_data_o      (wr_data),
      .wr_strb_o      (wr_strb),
      .system_reset_o (sys_rst),
      .prog_mode_led_o(led),
      .prog_err_o     (perr)
   );

   always #5 clk = ~clk;

   // one clock on the falling edge; scoreboard writes and tally status lines
   task automatic step();
      wr_t e;
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         if (wr_en) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL write_unexpected got addr=%0d data=%h, want no write", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data || wr_strb !== 4'hF) begin
                  failures++;
                  $display("FAIL write_payload got addr=%0d data=%h strb=%h, want addr=%0d data=%h strb=f",
                           wr_addr, wr_data, wr_strb, e.addr, e.data);
               end
            end
         end
         if (perr) begin
            if (n_err == 0) err_cyc = cyc;
            n_err++;
         end
         if (!sys_rst) n_lo++;
         if (led) n_led++;
      end
   endtask

   task automatic clear_stats();
      n_writes = 0;
      n_err    = 0;
      n_lo     = 0;
      n_led    = 0;
      err_cyc  = 0;
      exp_q.delete();
   endtask

   // 8N1 frame, 101 clocks per call; stop=0 forces a framing error
   task automatic send_byte(input logic [7:0] b, input logic stop);
      step();
      rx = 1'b0;
      last_fall = cyc;
      repeat (CPB) step();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) step();
      end
      rx = stop;
      repeat (CPB) step();
      rx = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic glitch();
      step();
      rx = 1'b0;
      repeat (3) step();
      rx = 1'b1;
      repeat (20) step();
   endtask

   task automatic push_exp(input int a, input logic [31:0] d);
      wr_t e;
      e.addr = AW'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      repeat (4) step();
      checks += 7;
      if (wr_en !== 1'b0)   begin failures++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
      if (wr_addr !== '0)   begin failures++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
      if (wr_data !== '0)   begin failures++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
      if (wr_strb !== 4'h0) begin failures++; $display("FAIL reset_wr_strb got %h want 0", wr_strb); end
      if (sys_rst !== 1'b1) begin failures++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
      if (led !== 1'b0)     begin failures++; $display("FAIL reset_led got %b want 0", led); end
      if (perr !== 1'b0)    begin failures++; $display("FAIL reset_err got %b want 0", perr); end
      rst_n = 1'b1;
      repeat (30) step();
   endtask

   task automatic test_basic_load();
      clear_stats();
      push_exp(0, 32'h1234_5678);
      push_exp(1, 32'hDEAD_BEEF);
      send_word(32'h4B47_4F54);
      send_word(32'h0000_0002);
      send_byte(8'h78, 1'b1);
      checks += 2;
      if (led !== 1'b1)     begin failures++; $display("FAIL basic_led_mid got %b want 1", led); end
      if (sys_rst !== 1'b0) begin failures++; $display("FAIL basic_rst_mid got %b want 0", sys_rst); end
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      send_word(32'hDEAD_BEEF);
      repeat (40) step();
      checks += 5;
      if (n_writes != 2)        begin failures++; $display("FAIL basic_writes got %0d want 2", n_writes); end
      if (exp_q.size() != 0)    begin failures++; $display("FAIL basic_pending got %0d want 0", exp_q.size()); end
      if (n_err != 0)           begin failures++; $display("FAIL basic_err got %0d want 0", n_err); end
      if (n_lo != n_led + 1)    begin failures++; $display("FAIL basic_done_cycle got lo=%0d led=%0d want lo=led+1", n_lo, n_led); end
      if (sys_rst !== 1'b1 || led !== 1'b0) begin
         failures++; $display("FAIL basic_release got rst=%b led=%b want rst=1 led=0", sys_rst, led);
      end
   endtask

   task automatic test_resync();
      clear_stats();
      send_byte(8'h54, 1'b1);
      send_word(32'h4B47_4F54);
      send_word(32'h0000_0000);
      repeat (40) step();
      checks += 3;
      if (n_led != 404)   begin failures++; $display("FAIL resync_led_cycles got %0d want 404", n_led); end
      if (n_lo != 405)    begin failures++; $display("FAIL resync_rst_cycles got %0d want 405", n_lo); end
      if (n_writes != 0)  begin failures++; $display("FAIL resync_writes got %0d want 0", n_writes); end
   endtask

   task automatic test_glitch_idle();
      clear_stats();
      send_byte(8'h54, 1'b1);
      glitch();
      send_byte(8'h4F, 1'b1);
      send_byte(8'h47, 1'b1);
      send_byte(8'h4B, 1'b1);
      send_word(32'h0000_0000);
      repeat (40) step();
      checks += 2;
      if (n_lo != 405)   begin failures++; $display("FAIL glitch_idle_rst_cycles got %0d want 405", n_lo); end
      if (n_err != 0)    begin failures++; $display("FAIL glitch_idle_err got %0d want 0", n_err); end
   endtask

   task automatic test_glitch_load();
      clear_stats();
      push_exp(0, 32'h4433_2211);
      send_word(32'h4B47_4F54);
      send_word(32'h0000_0001);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      glitch();
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      repeat (40) step();
      checks += 3;
      if (n_writes != 1)     begin failures++; $display("FAIL glitch_load_writes got %0d want 1", n_writes); end
      if (exp_q.size() != 0) begin failures++; $display("FAIL glitch_load_pending got %0d want 0", exp_q.size()); end
      if (n_err != 0)        begin failures++; $display("FAIL glitch_load_err got %0d want 0", n_err); end
   endtask

   task automatic test_frame_err();
      clear_stats();
      send_word(32'h4B47_4F54);
      send_word(32'h0000_0002);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b0);
      repeat (40) step();
      checks += 4;
      if (n_err != 1)        begin failures++; $display("FAIL ferr_pulse_cycles got %0d want 1", n_err); end
      if (n_writes != 0)     begin failures++; $display("FAIL ferr_writes got %0d want 0", n_writes); end
      if (n_lo != n_led)     begin failures++; $display("FAIL ferr_release got lo=%0d led=%0d want equal", n_lo, n_led); end
      if (sys_rst !== 1'b1 || led !== 1'b0) begin
         failures++; $display("FAIL ferr_state got rst=%b led=%b want rst=1 led=0", sys_rst, led);
      end
      // a fresh load must not see the discarded partial word
      clear_stats();
      push_exp(0, 32'h0BAD_F00D);
      send_word(32'h4B47_4F54);
      send_word(32'h0000_0001);
      send_word(32'h0BAD_F00D);
      repeat (40) step();
      checks += 1;
      if (n_writes != 1 || exp_q.size() != 0) begin
         failures++; $display("FAIL ferr_reload got writes=%0d pending=%0d want 1/0", n_writes, exp_q.size());
      end
   endtask

   task automatic test_timeout();
      int start;
      clear_stats();
      send_word(32'h4B47_4F54);
      send_word(32'h0000_0001);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      start = last_fall;
      for (int i = 0; i < 800 && n_err == 0; i++) step();
      repeat (20) step();
      checks += 4;
      if (n_err != 1) begin
         failures++; $display("FAIL timeout_pulse got %0d cycles want 1", n_err);
      end else if (err_cyc - start < 596 || err_cyc - start > 600) begin
         failures++; $display("FAIL timeout_delay got %0d clocks from last start edge want 596..600", err_cyc - start);
      end
      if (n_writes != 0)    begin failures++; $display("FAIL timeout_writes got %0d want 0", n_writes); end
      if (sys_rst !== 1'b1) begin failures++; $display("FAIL timeout_rst got %b want 1", sys_rst); end
      if (led !== 1'b0)     begin failures++; $display("FAIL timeout_led got %b want 0", led); end
   endtask

   task automatic test_overflow();
      clear_stats();
      for (int i = 0; i < 16; i++) push_exp(i, 32'hC0DE_0000 | 32'(i));
      send_word(32'h4B47_4F54);
      send_word(32'd18);
      for (int i = 0; i < 18; i++) send_word(32'hC0DE_0000 | 32'(i));
      repeat (40) step();
      checks += 4;
      if (n_writes != 16)     begin failures++; $display("FAIL ovf_writes got %0d want 16", n_writes); end
      if (exp_q.size() != 0)  begin failures++; $display("FAIL ovf_pending got %0d want 0", exp_q.size()); end
      if (n_lo != n_led + 1)  begin failures++; $display("FAIL ovf_done_cycle got lo=%0d led=%0d want lo=led+1", n_lo, n_led); end
      if (n_err != 0)         begin failures++; $display("FAIL ovf_err got %0d want 0", n_err); end
   endtask

   task automatic test_async_reset();
      clear_stats();
      push_exp(0, 32'h5A5A_A5A5);
      send_word(32'h4B47_4F54);
      send_word(32'd4);
      send_word(32'h5A5A_A5A5);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      step();
      rx = 1'b0;
      repeat (15) step();
      #2 rst_n = 1'b0;
      #1;
      checks += 7;
      if (wr_en !== 1'b0)   begin failures++; $display("FAIL arst_wr_en got %b want 0", wr_en); end
      if (wr_addr !== '0)   begin failures++; $display("FAIL arst_wr_addr got %h want 0", wr_addr); end
      if (wr_data !== '0)   begin failures++; $display("FAIL arst_wr_data got %h want 0", wr_data); end
      if (wr_strb !== 4'h0) begin failures++; $display("FAIL arst_wr_strb got %h want 0", wr_strb); end
      if (sys_rst !== 1'b1) begin failures++; $display("FAIL arst_sys_rst got %b want 1", sys_rst); end
      if (led !== 1'b0)     begin failures++; $display("FAIL arst_led got %b want 0", led); end
      if (perr !== 1'b0)    begin failures++; $display("FAIL arst_err got %b want 0", perr); end
      rx = 1'b1;
      repeat (20) step();
      rst_n = 1'b1;
      repeat (400) step();
      checks += 2;
      if (n_writes != 1)    begin failures++; $display("FAIL arst_writes got %0d want 1", n_writes); end
      if (sys_rst !== 1'b1 || led !== 1'b0 || n_err != 0) begin
         failures++; $display("FAIL arst_after got rst=%b led=%b errs=%0d want 1/0/0", sys_rst, led, n_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_resync();
      test_glitch_idle();
      test_glitch_load();
      test_frame_err();
      test_timeout();
      test_overflow();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
